// File: rtl/rom_fetch_unit_if.sv
// Fetch unit bus bundle: ROM port A, redirect request and the decode-side handshake.
// master is the fetch unit itself; slave is whatever drives ROM data, redirects and decode ready.
interface rom_fetch_unit_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        rom_en;
  logic [8:0]  rom_addr;
  logic [31:0] rom_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_fault;

  modport master (
    input  redirect_valid, redirect_pc, rom_data, inst_ready,
    output rom_en, rom_addr, inst_valid, inst_data, inst_pc, inst_fault
  );

  modport slave (
    output redirect_valid, redirect_pc, rom_data, inst_ready,
    input  rom_en, rom_addr, inst_valid, inst_data, inst_pc, inst_fault
  );
endinterface

// File: rtl/rom_fetch_unit.sv
// Instruction fetch front-end for the boot ROM: owns the fetch PC, issues ROM reads and
// buffers returned words (or fault markers for bad PCs) in a small prefetch FIFO for decode.
module rom_fetch_unit #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst_n,
  rom_fetch_unit_if.master bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = DEPTH[CW-1:0];

  typedef enum logic {
    ST_RUN,
    ST_HALT
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [31:0]   fetch_pc;
  logic [31:0]   mem_data  [DEPTH];
  logic [31:0]   mem_pc    [DEPTH];
  logic          mem_fault [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic bad_pc;
  logic issue;
  logic push;
  logic pop;
  logic head_valid;

  // A PC is bad when it leaves the 2 KiB window or is not word aligned.
  assign bad_pc     = (fetch_pc[31:11] != 21'd0) || (fetch_pc[1:0] != 2'd0);
  assign head_valid = (count != '0);
  assign push       = issue;
  assign pop        = head_valid && bus.inst_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // A bad PC produces exactly one fault entry and then parks the unit until a redirect.
  always_comb begin
    state_nxt = state;
    if (bus.redirect_valid) begin
      state_nxt = ST_RUN;
    end else if (issue && bad_pc) begin
      state_nxt = ST_HALT;
    end
  end

  // Issue looks at the registered count only, so decode ready never reaches the ROM enable.
  always_comb begin
    issue      = 1'b0;
    bus.rom_en = 1'b0;
    if (rst_n && (state == ST_RUN) && !bus.redirect_valid && (count < FULL_COUNT)) begin
      issue      = 1'b1;
      bus.rom_en = !bad_pc;
    end
  end

  assign bus.rom_addr = fetch_pc[10:2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
    end else if (bus.redirect_valid) begin
      fetch_pc <= bus.redirect_pc;
    end else if (issue && !bad_pc) begin
      fetch_pc <= fetch_pc + 32'd4;
    end
  end

  // Redirect flushes everything, including an entry decode accepts in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (bus.redirect_valid) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr]  <= bad_pc ? 32'd0 : bus.rom_data;
      mem_pc[wr_ptr]    <= fetch_pc;
      mem_fault[wr_ptr] <= bad_pc;
    end
  end

  // Stale storage stays hidden: an empty FIFO presents all-zero outputs.
  assign bus.inst_valid = head_valid;
  assign bus.inst_data  = head_valid ? mem_data[rd_ptr]  : 32'd0;
  assign bus.inst_pc    = head_valid ? mem_pc[rd_ptr]    : 32'd0;
  assign bus.inst_fault = head_valid ? mem_fault[rd_ptr] : 1'b0;

endmodule

// File: tb/tb_rom_fetch_unit.sv
// Bench for rom_fetch_unit: directed scenarios plus random traffic, checked against a
// queue-based model of the fetch stream and a falling-edge ROM model.
module tb_rom_fetch_unit;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct {
    logic [31:0] data;
    logic [31:0] pc;
    logic        fault;
  } entry_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] rom_mem [512];
  logic [31:0] rom_q;

  entry_t      q[$];
  logic [31:0] m_pc;
  bit          m_halted;

  int tests;
  int fails;

  rom_fetch_unit_if bus ();

  rom_fetch_unit #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Boot ROM port A: latches the address on the falling edge when enabled.
  always @(negedge clk) begin
    if (bus.rom_en) begin
      rom_q <= rom_mem[bus.rom_addr];
    end
  end
  assign bus.rom_data = rom_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit model_bad(input logic [31:0] pc);
    return (pc > 32'h0000_07FF) || (pc % 4 != 0);
  endfunction

  task automatic model_reset();
    q.delete();
    m_pc     = RESET_PC;
    m_halted = 0;
  endtask

  task automatic checkOutput(input string tag, input bit exp_en);
    entry_t head;
    head = '{data: 32'd0, pc: 32'd0, fault: 1'b0};
    if (q.size() != 0) head = q[0];
    chk({tag, ".rom_en"},     {31'd0, bus.rom_en},     {31'd0, exp_en});
    chk({tag, ".rom_addr"},   {23'd0, bus.rom_addr},   (m_pc / 4) % 512);
    chk({tag, ".inst_valid"}, {31'd0, bus.inst_valid}, (q.size() != 0) ? 32'd1 : 32'd0);
    chk({tag, ".inst_data"},  bus.inst_data,           head.data);
    chk({tag, ".inst_pc"},    bus.inst_pc,             head.pc);
    chk({tag, ".inst_fault"}, {31'd0, bus.inst_fault}, {31'd0, head.fault});
  endtask

  task automatic checkReset(input string tag);
    chk({tag, ".rom_en"},     {31'd0, bus.rom_en},     32'd0);
    chk({tag, ".inst_valid"}, {31'd0, bus.inst_valid}, 32'd0);
    chk({tag, ".inst_data"},  bus.inst_data,           32'd0);
    chk({tag, ".inst_pc"},    bus.inst_pc,             32'd0);
    chk({tag, ".inst_fault"}, {31'd0, bus.inst_fault}, 32'd0);
  endtask

  // One clock cycle: drive inputs, check the cycle's outputs, then advance the model over the edge.
  task automatic applyStimulus(input string tag, input logic rv, input logic [31:0] rpc, input logic rdy);
    bit issue;
    bit bad;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.inst_ready     = rdy;
    #1;
    bad   = model_bad(m_pc);
    issue = !m_halted && !rv && (q.size() < DEPTH);
    checkOutput(tag, issue && !bad);
    @(posedge clk);
    if (rv) begin
      q.delete();
      m_pc     = rpc;
      m_halted = 0;
    end else begin
      if (q.size() != 0 && rdy) void'(q.pop_front());
      if (issue) begin
        if (!bad) begin
          q.push_back('{data: rom_mem[(m_pc / 4) % 512], pc: m_pc, fault: 1'b0});
          m_pc = m_pc + 32'd4;
        end else begin
          q.push_back('{data: 32'd0, pc: m_pc, fault: 1'b1});
          m_halted = 1;
        end
      end
    end
    #1;
  endtask

  initial begin
    logic [31:0] rpc;
    tests = 0;
    fails = 0;
    rom_q = 32'd0;
    for (int i = 0; i < 512; i++) rom_mem[i] = $urandom;
    rom_mem[0]     = 32'h080000f1;
    rom_mem[1]     = 32'h00000000;
    rom_mem[9'hE9] = 32'h1088ffc2;

    rst_n              = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'd0;
    bus.inst_ready     = 1'b0;
    model_reset();
    #2;
    checkReset("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // First words after reset release.
    applyStimulus("boot0", 1'b0, 32'd0, 1'b1);
    chk("boot.head0.data", bus.inst_data, 32'h080000f1);
    chk("boot.head0.pc",   bus.inst_pc,   32'd0);
    applyStimulus("boot1", 1'b0, 32'd0, 1'b1);
    chk("boot.head1.data", bus.inst_data, 32'h00000000);
    chk("boot.head1.pc",   bus.inst_pc,   32'd4);
    for (int i = 0; i < 4; i++) applyStimulus("stream", 1'b0, 32'd0, 1'b1);

    // Backpressure fills the FIFO, then drains in order.
    for (int i = 0; i < 6; i++) applyStimulus("stall", 1'b0, 32'd0, 1'b0);
    chk("stall.rom_en_low", {31'd0, bus.rom_en}, 32'd0);
    for (int i = 0; i < 5; i++) applyStimulus("drain", 1'b0, 32'd0, 1'b1);

    // Redirect with a full FIFO.
    for (int i = 0; i < 3; i++) applyStimulus("fill", 1'b0, 32'd0, 1'b0);
    applyStimulus("redir3a4", 1'b1, 32'h3A4, 1'b1);
    applyStimulus("after3a4", 1'b0, 32'd0, 1'b0);
    chk("redir3a4.data", bus.inst_data, 32'h1088ffc2);
    chk("redir3a4.pc",   bus.inst_pc,   32'h3A4);
    for (int i = 0; i < 4; i++) applyStimulus("run3a4", 1'b0, 32'd0, 1'b1);

    // Out-of-range redirect: one fault entry, then halted.
    applyStimulus("redir800", 1'b1, 32'h800, 1'b0);
    applyStimulus("fault800", 1'b0, 32'd0, 1'b0);
    chk("fault800.fault", {31'd0, bus.inst_fault}, 32'd1);
    chk("fault800.data",  bus.inst_data,           32'd0);
    chk("fault800.pc",    bus.inst_pc,             32'h800);
    for (int i = 0; i < 3; i++) applyStimulus("halt800", 1'b0, 32'd0, 1'b0);
    chk("halt800.rom_en", {31'd0, bus.rom_en}, 32'd0);
    for (int i = 0; i < 3; i++) applyStimulus("halt800pop", 1'b0, 32'd0, 1'b1);
    applyStimulus("redir0", 1'b1, 32'd0, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus("resume0", 1'b0, 32'd0, 1'b1);

    // Misaligned redirect.
    applyStimulus("redir6", 1'b1, 32'h6, 1'b0);
    applyStimulus("fault6", 1'b0, 32'd0, 1'b0);
    chk("fault6.pc",    bus.inst_pc,             32'h6);
    chk("fault6.fault", {31'd0, bus.inst_fault}, 32'd1);
    for (int i = 0; i < 3; i++) applyStimulus("halt6", 1'b0, 32'd0, 1'b1);

    // Last word of the window rolls into a fault.
    applyStimulus("redir7f8", 1'b1, 32'h7F8, 1'b1);
    for (int i = 0; i < 6; i++) applyStimulus("edge7f8", 1'b0, 32'd0, 1'b1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 5))
        0:       rpc = 32'h7F8;
        1:       rpc = $urandom;
        2:       rpc = (32'($urandom_range(0, 511)) * 4) + 32'($urandom_range(1, 3));
        default: rpc = 32'($urandom_range(0, 511)) * 4;
      endcase
      applyStimulus("rand", ($urandom_range(0, 15) == 0), rpc, ($urandom_range(0, 3) != 0));
    end

    // Asynchronous reset in the middle of a buffered stream.
    applyStimulus("prerst", 1'b1, 32'h100, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus("prerst", 1'b0, 32'd0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkReset("async_rst");
    @(posedge clk);
    #1;
    checkReset("held_rst");
    model_reset();
    rst_n = 1'b1;
    applyStimulus("restart0", 1'b0, 32'd0, 1'b1);
    chk("restart.data", bus.inst_data, 32'h080000f1);
    chk("restart.pc",   bus.inst_pc,   RESET_PC);
    for (int i = 0; i < 4; i++) applyStimulus("restart", 1'b0, 32'd0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
